// File: rtl/filtro_botones_n.sv
// N-channel push-button front end: two-flop synchroniser, counter debounce,
// one-cycle press pulse with optional hold-to-repeat, and a lowest-index event code.
module filtro_botones_n #(
  parameter int unsigned N_BOTONES      = 4,
  parameter int unsigned CONTEO_ESTABLE = 100000,
  parameter int unsigned REPETIR        = 0,
  parameter int unsigned RETARDO_REP    = 50000000,
  parameter int unsigned PERIODO_REP    = 10000000,
  localparam int unsigned CODIGO_W      = (N_BOTONES > 1) ? $clog2(N_BOTONES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [N_BOTONES-1:0] botones_i,
  output logic [N_BOTONES-1:0] estado_o,
  output logic [N_BOTONES-1:0] pulso_o,
  output logic                 pulso_any_o,
  output logic [CODIGO_W-1:0]  codigo_o
);

  localparam int unsigned CONT_W  = $clog2(CONTEO_ESTABLE);
  localparam int unsigned REP_MAX = (RETARDO_REP > PERIODO_REP) ? RETARDO_REP : PERIODO_REP;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {
    REPOSO,
    PRIMERO,
    PERIODO
  } estadoRep_t;

  logic [N_BOTONES-1:0] sinc1;
  logic [N_BOTONES-1:0] sinc2;
  logic [CONT_W-1:0]    cuenta     [N_BOTONES];
  logic [CONT_W-1:0]    cuentaNext [N_BOTONES];
  logic [REP_W-1:0]     rep        [N_BOTONES];
  logic [REP_W-1:0]     repNext    [N_BOTONES];
  estadoRep_t           fsm        [N_BOTONES];
  estadoRep_t           fsmNext    [N_BOTONES];
  logic [N_BOTONES-1:0] estadoNext;
  logic [N_BOTONES-1:0] pulsoNext;

  // State register for synchronisers, debounce, repeat machines and outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sinc1    <= '0;
      sinc2    <= '0;
      estado_o <= '0;
      pulso_o  <= '0;
      for (int k = 0; k < int'(N_BOTONES); k++) begin
        cuenta[k] <= '0;
        rep[k]    <= '0;
        fsm[k]    <= REPOSO;
      end
    end else begin
      sinc1    <= botones_i;
      sinc2    <= sinc1;
      estado_o <= estadoNext;
      pulso_o  <= pulsoNext;
      for (int k = 0; k < int'(N_BOTONES); k++) begin
        cuenta[k] <= cuentaNext[k];
        rep[k]    <= repNext[k];
        fsm[k]    <= fsmNext[k];
      end
    end
  end

  // Next-state: debounce acceptance, press detection and repeat timing
  always_comb begin
    logic sube;
    logic baja;
    estadoNext = estado_o;
    pulsoNext  = '0;
    cuentaNext = cuenta;
    repNext    = rep;
    fsmNext    = fsm;
    sube       = 1'b0;
    baja       = 1'b0;
    for (int k = 0; k < int'(N_BOTONES); k++) begin
      if (sinc2[k] == estado_o[k]) begin
        cuentaNext[k] = '0;
      end else if (cuenta[k] == CONT_W'(CONTEO_ESTABLE - 1)) begin
        cuentaNext[k] = '0;
        estadoNext[k] = ~estado_o[k];
      end else begin
        cuentaNext[k] = cuenta[k] + CONT_W'(1);
      end

      sube = ~estado_o[k] & estadoNext[k];
      baja = estado_o[k] & ~estadoNext[k];
      if (sube) pulsoNext[k] = 1'b1;

      if (REPETIR != 0) begin
        // Release wins over a coinciding repeat so no pulse lands in the release cycle
        case (fsm[k])
          REPOSO: begin
            repNext[k] = '0;
            if (sube) fsmNext[k] = PRIMERO;
          end
          PRIMERO: begin
            if (baja) begin
              repNext[k] = '0;
              fsmNext[k] = REPOSO;
            end else if (rep[k] == REP_W'(RETARDO_REP - 1)) begin
              repNext[k]   = '0;
              pulsoNext[k] = 1'b1;
              fsmNext[k]   = PERIODO;
            end else begin
              repNext[k] = rep[k] + REP_W'(1);
            end
          end
          PERIODO: begin
            if (baja) begin
              repNext[k] = '0;
              fsmNext[k] = REPOSO;
            end else if (rep[k] == REP_W'(PERIODO_REP - 1)) begin
              repNext[k]   = '0;
              pulsoNext[k] = 1'b1;
            end else begin
              repNext[k] = rep[k] + REP_W'(1);
            end
          end
          default: begin
            repNext[k] = '0;
            fsmNext[k] = REPOSO;
          end
        endcase
      end
    end
  end

  // Lowest-index pulse wins the event code
  always_comb begin
    codigo_o    = '0;
    pulso_any_o = |pulso_o;
    for (int k = int'(N_BOTONES) - 1; k >= 0; k--) begin
      if (pulso_o[k]) codigo_o = CODIGO_W'(k);
    end
  end

endmodule
